// File: rtl/bearcore_clint_timer_if.sv
// Register bus between the core and the CLINT-lite timer: single-cycle request,
// one-cycle acknowledge with read data and an error flag for unmapped offsets.
interface bearcore_clint_timer_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, err
  );
endinterface

// File: rtl/bearcore_clint_timer.sv
// CLINT-lite: prescaled 64-bit mtime, mtimecmp compare driving a level timer IRQ,
// msip software IRQ, and an atomic hi-shadow for split 32-bit mtime reads.
module bearcore_clint_timer #(
  parameter int unsigned PRESCALE_W = 8,
  parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int unsigned ADDR_W     = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bearcore_clint_timer_if.slave   bus,
  output logic                    timer_irq_o,
  output logic                    soft_irq_o,
  output logic [63:0]             mtime_o
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned DIV_LSB = 8;

  localparam logic [ADDR_W-1:0] OFF_MSIP   = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] OFF_CMP_LO = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] OFF_CMP_HI = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] OFF_MT_LO  = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] OFF_MT_HI  = ADDR_W'(32'h10);
  localparam logic [ADDR_W-1:0] OFF_CTRL   = ADDR_W'(32'h14);

  // Architectural state
  logic [63:0]           mtime_q,  mtime_d;
  logic [63:0]           cmp_q,    cmp_d;
  logic                  msip_q,   msip_d;
  logic                  en_q,     en_d;
  logic [PRESCALE_W-1:0] div_q,    div_d;
  logic [PRESCALE_W-1:0] cnt_q,    cnt_d;
  logic [DATA_W-1:0]     shadow_q, shadow_d;

  // Registered outputs
  logic              ack_q,   ack_d;
  logic              err_q,   err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              tirq_q,  tirq_d;
  logic              sirq_q,  sirq_d;

  // Decode
  logic [ADDR_W-1:0] word_addr;
  logic              wr, rd;
  logic              sel_msip, sel_cmp_lo, sel_cmp_hi;
  logic              sel_mt_lo, sel_mt_hi, sel_ctrl, mapped;
  logic              tick_c;

  always_comb begin
    word_addr  = bus.addr & ~ADDR_W'(32'h3);
    wr         = bus.req &  bus.we;
    rd         = bus.req & ~bus.we;
    sel_msip   = (word_addr == OFF_MSIP);
    sel_cmp_lo = (word_addr == OFF_CMP_LO);
    sel_cmp_hi = (word_addr == OFF_CMP_HI);
    sel_mt_lo  = (word_addr == OFF_MT_LO);
    sel_mt_hi  = (word_addr == OFF_MT_HI);
    sel_ctrl   = (word_addr == OFF_CTRL);
    mapped     = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_mt_lo | sel_mt_hi | sel_ctrl;
    tick_c     = en_q && (cnt_q == div_q);
  end

  // Prescaler and CTRL: a CTRL write restarts the divider from zero
  always_comb begin
    en_d  = en_q;
    div_d = div_q;
    cnt_d = cnt_q;
    if (wr && sel_ctrl) begin
      en_d  = bus.wdata[0];
      div_d = bus.wdata[DIV_LSB +: PRESCALE_W];
      cnt_d = '0;
    end else if (!en_q || tick_c) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PRESCALE_W'(1);
    end
  end

  // mtime: a bus write to either half replaces it and suppresses that cycle's tick
  always_comb begin
    mtime_d = mtime_q;
    if (wr && sel_mt_lo) begin
      mtime_d[31:0] = bus.wdata;
    end else if (wr && sel_mt_hi) begin
      mtime_d[63:32] = bus.wdata;
    end else if (tick_c) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  // mtimecmp, msip and the hi shadow captured on an MTIME_LO read
  always_comb begin
    cmp_d    = cmp_q;
    msip_d   = msip_q;
    shadow_d = shadow_q;
    if (wr && sel_cmp_lo) cmp_d[31:0]  = bus.wdata;
    if (wr && sel_cmp_hi) cmp_d[63:32] = bus.wdata;
    if (wr && sel_msip)   msip_d       = bus.wdata[0];
    if (rd && sel_mt_lo)  shadow_d     = mtime_q[63:32];
  end

  // Read mux and handshake; read data reflects state before this edge
  always_comb begin
    rdata_d = '0;
    ack_d   = bus.req;
    err_d   = bus.req & ~mapped;
    if (rd) begin
      if (sel_msip)   rdata_d = DATA_W'(msip_q);
      if (sel_cmp_lo) rdata_d = cmp_q[31:0];
      if (sel_cmp_hi) rdata_d = cmp_q[63:32];
      if (sel_mt_lo)  rdata_d = mtime_q[31:0];
      if (sel_mt_hi)  rdata_d = shadow_q;
      if (sel_ctrl)   rdata_d = (DATA_W'(div_q) << DIV_LSB) | DATA_W'(en_q);
    end
  end

  // Interrupt levels track the post-edge register values
  always_comb begin
    tirq_d = (mtime_d >= cmp_d);
    sirq_d = msip_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q  <= '0;
      cmp_q    <= CMP_RESET;
      msip_q   <= 1'b0;
      en_q     <= 1'b0;
      div_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      tirq_q   <= 1'b0;
      sirq_q   <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      msip_q   <= msip_d;
      en_q     <= en_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      tirq_q   <= tirq_d;
      sirq_q   <= sirq_d;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.err     = err_q;
  assign bus.rdata   = rdata_q;
  assign timer_irq_o = tirq_q;
  assign soft_irq_o  = sirq_q;
  assign mtime_o     = mtime_q;

endmodule

// File: tb/tb_bearcore_clint_timer.sv
// Directed and randomized checks of bearcore_clint_timer against a cycle-level
// arithmetic model of the register map, prescaler and compare rules.
module tb_bearcore_clint_timer;

  logic        clk;
  logic        rst_n;
  logic        timer_irq;
  logic        soft_irq;
  logic [63:0] mtime;

  bearcore_clint_timer_if #(.ADDR_W(5)) bus_if ();

  bearcore_clint_timer #(
    .PRESCALE_W(8),
    .CMP_RESET (64'hFFFF_FFFF_FFFF_FFFF),
    .ADDR_W    (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_if),
    .timer_irq_o(timer_irq),
    .soft_irq_o (soft_irq),
    .mtime_o    (mtime)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip, m_en;
  int unsigned m_div, m_phase;
  logic [31:0] m_shadow;
  logic        e_ack, e_err, e_irq, e_soft;
  logic [31:0] e_rdata;
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mtime = '0; m_cmp = '1; m_msip = 1'b0; m_en = 1'b0;
    m_div = 0; m_phase = 0; m_shadow = '0;
    e_ack = 1'b0; e_err = 1'b0; e_irq = 1'b0; e_soft = 1'b0; e_rdata = '0;
  endtask

  // Advance the model across one clock edge with the given request
  task automatic model_edge(input bit req, input bit we, input logic [4:0] addr,
                            input logic [31:0] wdata);
    logic [4:0]  wa;
    logic [63:0] nt;
    bit          tick, wrote;
    wa    = addr & 5'h1C;
    tick  = m_en && ((m_phase % (m_div + 1)) == m_div);
    e_ack = req;
    e_err = req && (wa > 5'h14);
    e_rdata = '0;
    if (req && !we) begin
      case (wa)
        5'h00: e_rdata = {31'b0, m_msip};
        5'h04: e_rdata = m_cmp[31:0];
        5'h08: e_rdata = m_cmp[63:32];
        5'h0C: begin e_rdata = m_mtime[31:0]; m_shadow = m_mtime[63:32]; end
        5'h10: e_rdata = m_shadow;
        5'h14: e_rdata = (32'(m_div) << 8) | 32'(m_en);
        default: e_rdata = '0;
      endcase
    end
    nt = m_mtime;
    wrote = 1'b0;
    if (req && we) begin
      case (wa)
        5'h00: m_msip = wdata[0];
        5'h04: m_cmp[31:0] = wdata;
        5'h08: m_cmp[63:32] = wdata;
        5'h0C: begin nt[31:0] = wdata; wrote = 1'b1; end
        5'h10: begin nt[63:32] = wdata; wrote = 1'b1; end
        default: ;
      endcase
    end
    if (!wrote && tick) nt = m_mtime + 64'd1;
    m_mtime = nt;
    if (req && we && wa == 5'h14) begin
      m_en = wdata[0]; m_div = 32'(wdata[15:8]); m_phase = 0;
    end else if (m_en) begin
      m_phase++;
    end else begin
      m_phase = 0;
    end
    e_irq  = (m_mtime >= m_cmp);
    e_soft = m_msip;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ack"},   64'(bus_if.ack),   64'(e_ack));
    check({tag, ".err"},   64'(bus_if.err),   64'(e_err));
    check({tag, ".rdata"}, 64'(bus_if.rdata), 64'(e_rdata));
    check({tag, ".mtime"}, mtime,             m_mtime);
    check({tag, ".tirq"},  64'(timer_irq),    64'(e_irq));
    check({tag, ".sirq"},  64'(soft_irq),     64'(e_soft));
  endtask

  // Called at a falling edge; drives one cycle, checks after the rising edge
  task automatic cycle(input string tag, input bit req, input bit we,
                       input logic [4:0] addr, input logic [31:0] wdata);
    bus_if.req = req; bus_if.we = we; bus_if.addr = addr; bus_if.wdata = wdata;
    model_edge(req, we, addr, wdata);
    @(posedge clk); #1;
    check_all(tag);
    last_rdata = bus_if.rdata;
    @(negedge clk);
    bus_if.req = 1'b0; bus_if.we = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    cycle(tag, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input string tag, input logic [4:0] a);
    cycle(tag, 1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle("idle", 1'b0, 1'b0, 5'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] l1, l2, h1, l3, h2;
    logic [4:0]  ra;
    logic [31:0] rw;
    bit          prev_irq, hit;

    rst_n = 1'b0;
    bus_if.req = 1'b0; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst.tirq", 64'(timer_irq), 64'd0);
    check("rst.sirq", 64'(soft_irq), 64'd0);
    check("rst.mtime", mtime, 64'd0);
    check("rst.ack", 64'(bus_if.ack), 64'd0);
    rst_n = 1'b1;

    // Reset values through the bus; ack lasts exactly one cycle
    rd("rd_cmp_lo", 5'h04);
    check("cmp_lo_reset", 64'(last_rdata), 64'hFFFF_FFFF);
    rd("rd_cmp_hi", 5'h08);
    check("cmp_hi_reset", 64'(last_rdata), 64'hFFFF_FFFF);
    idle(1);

    // Prescaler: DIV=3 for 40 cycles, then disabled
    wr("ctrl_div3", 5'h14, 32'h0000_0301);
    rd("rd_ctrl", 5'h14);
    idle(39);
    check("prescale_10", mtime, 64'd10);
    wr("ctrl_off", 5'h14, 32'h0);
    idle(5);
    check("frozen_10", mtime, 64'd10);

    // Compare: rises in the cycle mtime reaches 20, clears after cmp raised
    wr("cmp_hi0", 5'h08, 32'h0);
    wr("cmp_lo20", 5'h04, 32'd20);
    wr("ctrl_div0", 5'h14, 32'h1);
    hit = 1'b0;
    prev_irq = timer_irq;
    for (int i = 0; i < 30 && !hit; i++) begin
      idle(1);
      if (mtime == 64'd20) begin
        hit = 1'b1;
        check("irq_at_20", 64'(timer_irq), 64'd1);
        check("irq_before_20", 64'(prev_irq), 64'd0);
      end
      prev_irq = timer_irq;
    end
    check("reached_20", 64'(hit), 64'd1);
    idle(3);
    check("irq_stays", 64'(timer_irq), 64'd1);
    wr("cmp_lo100", 5'h04, 32'd100);
    check("irq_clear", 64'(timer_irq), 64'd0);

    // Carry across the 32-bit boundary and atomic split read
    wr("ctrl_off2", 5'h14, 32'h0);
    wr("mt_hi0", 5'h10, 32'h0);
    wr("mt_lo_fe", 5'h0C, 32'hFFFF_FFFE);
    wr("ctrl_run", 5'h14, 32'h1);
    rd("rd_lo1", 5'h0C); l1 = last_rdata;
    rd("rd_lo2", 5'h0C); l2 = last_rdata;
    rd("rd_hi1", 5'h10); h1 = last_rdata;
    rd("rd_lo3", 5'h0C); l3 = last_rdata;
    rd("rd_hi2", 5'h10); h2 = last_rdata;
    check("lo_first", 64'(l1), 64'hFFFF_FFFE);
    check("atomic_straddle", {h1, l2}, 64'h0000_0000_FFFF_FFFF);
    check("atomic_after", {h2, l3}, 64'h0000_0001_0000_0001);
    check("mtime_carried", mtime, 64'h0000_0001_0000_0003);

    // Write collides with a tick: write wins
    wr("mt_lo55", 5'h0C, 32'h55);
    check("collide_lo", 64'(mtime[31:0]), 64'h55);
    check("collide_hi", 64'(mtime[63:32]), 64'h1);

    // MSIP and unmapped offsets
    wr("msip_set", 5'h00, 32'h1);
    check("soft_set", 64'(soft_irq), 64'd1);
    wr("unmapped_wr", 5'h18, 32'hDEAD_BEEF);
    check("unmapped_wr_err", 64'(bus_if.err), 64'd1);
    rd("unmapped_rd", 5'h1C);
    check("unmapped_rd_data", 64'(last_rdata), 64'd0);
    rd("rd_msip", 5'h00);

    // Reset asserted while a write is pending: no ack, write lost
    bus_if.req = 1'b1; bus_if.we = 1'b1; bus_if.addr = 5'h0C; bus_if.wdata = 32'h1234;
    #2 rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_all("rst_mid");
    @(negedge clk);
    bus_if.req = 1'b0; bus_if.we = 1'b0;
    rst_n = 1'b1;
    rd("post_rst_lo", 5'h0C);
    rd("post_rst_msip", 5'h00);

    // Randomized traffic against the model
    wr("rnd_cmp_hi", 5'h08, 32'h0);
    wr("rnd_cmp_lo", 5'h04, 32'd40);
    for (int i = 0; i < 400; i++) begin
      ra = 5'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      case (ra & 5'h1C)
        5'h14:   rw = ($urandom_range(0, 3) << 8) | $urandom_range(0, 1);
        5'h08,
        5'h10:   rw = ($urandom_range(0, 7) == 0) ? 32'h1 : 32'h0;
        default: rw = $urandom_range(0, 80);
      endcase
      if ($urandom_range(0, 9) < 6)
        cycle("rnd", 1'b1, 1'($urandom_range(0, 1)), ra, rw);
      else
        cycle("rnd_idle", 1'b0, 1'b0, 5'h0, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
